uart_sample_scheduler: RTL and testbench

Sequences audio samples onto the shared UART transmit path. It accepts the beamformed single-channel stream and the raw dual-mic stream as two requesters, and applies the active mode and dual-mode decimation. It holds at most one pending sample and issues a one-cycle trigger to the byte transmitter only when the transmitter is idle. It sits between the delay-sum-shift / TDM receive outputs and the `uart_byte_transmit` instances, replacing ad-hoc waiting/valid logic in `top_level`.

---
 rtl/uart_sample_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_uart_sample_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_scheduler.sv
// -----------------------------------------------------------------------------
// uart_sample_scheduler
//
// Puts audio samples onto the shared UART transmit path. Two requesters feed it:
// the beamformed single-channel stream (16 bit) and the raw dual-mic stream
// (32 bit). Only the requester that matches the active mode is captured. In
// dual mode, only every DECIMATE-th dual strobe is captured. One sample can be
// pending at a time; a newer capture overwrites it and bumps the drop counter.
// A one-cycle trigger starts the byte transmitter only when it is idle.
//
// Ports
//   clk_in          system clock (100 MHz)
//   rst_in          synchronous, active-high reset
//   enable_in       transmission enable; low blocks capture and flushes pending
//   mode_in         requested mode: 0 = single (16 bit), 1 = dual (32 bit)
//   single_data_in  single-stream sample, qualified by single_valid_in
//   single_valid_in one-cycle strobe
//   dual_data_in    {mic1[23:8], mic0[23:8]}, qualified by dual_valid_in
//   dual_valid_in   one-cycle strobe
//   tx_busy_in      busy flag of the selected transmitter
//   tx_data_out     word handed to the transmitter, held from trigger to trigger
//   tx_trigger_out  one-cycle start pulse
//   tx_sel_out      active mode; selects transmitter / byte count
//   drop_count_out  saturating count of overwritten samples
//   timeout_out     sticky; set when busy never rose after a trigger
//   fsm_state_out   current FSM state (0 idle, 1 wait busy, 2 wait done)
//
// Trigger/busy handshake: tx_trigger_out is a single-cycle request. The
// transmitter acknowledges by raising tx_busy_in within a few cycles and
// lowers it when the word is sent. A new trigger is issued only after busy
// has risen and fallen, or after BUSY_TIMEOUT cycles pass without busy rising.
// -----------------------------------------------------------------------------
module uart_sample_scheduler #(
   parameter int unsigned DECIMATE     = 2,
   parameter int unsigned BUSY_TIMEOUT = 8,
   parameter int unsigned DROP_W       = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              enable_in,
   input  logic              mode_in,
   input  logic [15:0]       single_data_in,
   input  logic              single_valid_in,
   input  logic [31:0]       dual_data_in,
   input  logic              dual_valid_in,
   input  logic              tx_busy_in,
   output logic [31:0]       tx_data_out,
   output logic              tx_trigger_out,
   output logic              tx_sel_out,
   output logic [DROP_W-1:0] drop_count_out,
   output logic              timeout_out,
   output logic [1:0]        fsm_state_out
);

   localparam logic [3:0]        PHASE_LAST = 4'(DECIMATE - 1);
   localparam logic [7:0]        WAIT_LAST  = 8'(BUSY_TIMEOUT - 1);
   localparam logic [DROP_W-1:0] DROP_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        active_mode_q;
   logic        pend_valid_q;
   logic [31:0] pend_data_q;
   logic [3:0]  phase_q;
   logic [7:0]  wait_cnt_q;

   logic        mode_mismatch;
   logic        dual_accept;
   logic        capture;
   logic [31:0] capture_data;
   logic        consume;
   logic        timeout_hit;

   // A pending mode change freezes the requesters until the FSM is idle and
   // the new mode can be latched.
   assign mode_mismatch = (mode_in != active_mode_q);

   // The phase counter follows dual strobes regardless of enable_in, so the
   // decimation pattern does not slip while transmission is paused.
   assign dual_accept = active_mode_q && dual_valid_in && !mode_mismatch;

   always_comb begin
      capture      = 1'b0;
      capture_data = {16'h0000, single_data_in};
      if (enable_in && !mode_mismatch) begin
         if (active_mode_q) begin
            capture      = dual_valid_in && (phase_q == PHASE_LAST);
            capture_data = dual_data_in;
         end else begin
            capture = single_valid_in;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      consume     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_valid_q && enable_in && !tx_busy_in && !mode_mismatch) begin
               consume = 1'b1;
               state_d = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            if (tx_busy_in) begin
               state_d = ST_WAIT_DONE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy_in) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q        <= ST_IDLE;
         active_mode_q  <= 1'b0;
         pend_valid_q   <= 1'b0;
         pend_data_q    <= '0;
         phase_q        <= '0;
         wait_cnt_q     <= '0;
         tx_data_out    <= '0;
         tx_trigger_out <= 1'b0;
         drop_count_out <= '0;
         timeout_out    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tx_trigger_out <= consume;
         if (consume) begin
            tx_data_out <= pend_data_q;
         end

         // Counts cycles spent in WAIT_BUSY; zero on entry because the
         // previous state always clears it.
         if (state_q == ST_WAIT_BUSY) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end else begin
            wait_cnt_q <= '0;
         end

         if (timeout_hit) begin
            timeout_out <= 1'b1;
         end

         if ((state_q == ST_IDLE) && mode_mismatch) begin
            active_mode_q <= mode_in;
            phase_q       <= '0;
         end else if (dual_accept) begin
            phase_q <= (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 1'b1;
         end

         // Pending slot. A capture in the cycle the slot is consumed simply
         // refills it; only a capture over an unconsumed entry is a drop.
         if (!enable_in || mode_mismatch) begin
            pend_valid_q <= 1'b0;
         end else if (capture) begin
            pend_valid_q <= 1'b1;
            pend_data_q  <= capture_data;
            if (pend_valid_q && !consume && (drop_count_out != DROP_MAX)) begin
               drop_count_out <= drop_count_out + 1'b1;
            end
         end else if (consume) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   assign tx_sel_out    = active_mode_q;
   assign fsm_state_out = state_q;

endmodule

// File: tb/tb_uart_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_sample_scheduler
//
// Directed scenarios for latency, overwrite, decimation, mode switch, busy
// timeout, reset and enable, followed by a randomized run. A transmitter model
// answers triggers with a configurable busy pulse. A transaction-level reference
// model predicts every output each cycle, and a queue of expected sent words
// is matched against each observed trigger.
// -----------------------------------------------------------------------------
module tb_uart_sample_scheduler;

   localparam int DECIMATE     = 2;
   localparam int BUSY_TIMEOUT = 8;
   localparam int DROP_W       = 16;
   localparam int DROP_SAT     = (1 << DROP_W) - 1;

   // ---------------------------------------------------------------- clock/reset
   logic              clk_in          = 1'b0;
   logic              rst_in          = 1'b1;
   logic              enable_in       = 1'b0;
   logic              mode_in         = 1'b0;
   logic [15:0]       single_data_in  = '0;
   logic              single_valid_in = 1'b0;
   logic [31:0]       dual_data_in    = '0;
   logic              dual_valid_in   = 1'b0;
   logic              tx_busy_in      = 1'b0;
   logic [31:0]       tx_data_out;
   logic              tx_trigger_out;
   logic              tx_sel_out;
   logic [DROP_W-1:0] drop_count_out;
   logic              timeout_out;
   logic [1:0]        fsm_state_out;

   always #5 clk_in = ~clk_in;

   uart_sample_scheduler #(
      .DECIMATE     (DECIMATE),
      .BUSY_TIMEOUT (BUSY_TIMEOUT),
      .DROP_W       (DROP_W)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .mode_in         (mode_in),
      .single_data_in  (single_data_in),
      .single_valid_in (single_valid_in),
      .dual_data_in    (dual_data_in),
      .dual_valid_in   (dual_valid_in),
      .tx_busy_in      (tx_busy_in),
      .tx_data_out     (tx_data_out),
      .tx_trigger_out  (tx_trigger_out),
      .tx_sel_out      (tx_sel_out),
      .drop_count_out  (drop_count_out),
      .timeout_out     (timeout_out),
      .fsm_state_out   (fsm_state_out)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------- transmitter model
   int tx_delay = 1;    // cycles from trigger to busy (1 or 2)
   int tx_len   = 4;    // cycles busy stays high
   bit tx_never = 1'b0; // never answers with busy
   int tx_dly   = 0;
   int tx_hold  = 0;

   always @(negedge clk_in) begin
      if (tx_trigger_out && !tx_never) tx_dly = tx_delay;
      if (tx_dly > 0) begin
         tx_dly--;
         if (tx_dly == 0) begin
            tx_busy_in = 1'b1;
            tx_hold    = tx_len;
         end
      end else if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0) tx_busy_in = 1'b0;
      end
   end

   // ------------------------------------------------------------ reference model
   // Sampled on the same edge as the DUT; its results are compared half a cycle
   // later. A transfer is "in flight" from the trigger until busy has been seen
   // high and then low, or until BUSY_TIMEOUT cycles pass with no busy.
   logic [31:0] exp_q[$];
   bit          m_mode, m_has, m_to, m_trig, m_inflight, m_busy_seen;
   bit          m_mism, m_idle, m_fire, m_take;
   logic [31:0] m_word, m_out_word, m_sample;
   int          m_phase, m_drop, m_age;

   always @(posedge clk_in) begin
      if (rst_in) begin
         m_mode = 0; m_has = 0; m_to = 0; m_trig = 0; m_inflight = 0; m_busy_seen = 0;
         m_word = '0; m_out_word = '0; m_phase = 0; m_drop = 0; m_age = 0;
         exp_q.delete();
      end else begin
         m_mism = (mode_in != m_mode);
         m_idle = !m_inflight;
         m_fire = m_idle && m_has && enable_in && !tx_busy_in && !m_mism;

         if (m_inflight) begin
            m_age++;
            if (!m_busy_seen) begin
               if (tx_busy_in) m_busy_seen = 1;
               else if (m_age >= BUSY_TIMEOUT) begin
                  m_to = 1;
                  m_inflight = 0;
               end
            end else if (!tx_busy_in) begin
               m_inflight = 0;
            end
         end

         m_trig = m_fire;
         if (m_fire) begin
            m_out_word = m_word;
            exp_q.push_back(m_word);
            m_inflight  = 1;
            m_busy_seen = 0;
            m_age       = 0;
         end

         m_take   = 0;
         m_sample = m_mode ? dual_data_in : {16'h0000, single_data_in};
         if (!m_mism) begin
            if (m_mode) begin
               if (dual_valid_in) begin
                  m_take  = enable_in && (m_phase == DECIMATE - 1);
                  m_phase = (m_phase + 1) % DECIMATE;
               end
            end else begin
               m_take = enable_in && single_valid_in;
            end
         end

         if (!enable_in || m_mism) begin
            m_has = 0;
         end else if (m_take) begin
            if (m_has && !m_fire && m_drop < DROP_SAT) m_drop++;
            m_has  = 1;
            m_word = m_sample;
         end else if (m_fire) begin
            m_has = 0;
         end

         if (m_mism && m_idle) begin
            m_mode  = mode_in;
            m_phase = 0;
         end
      end
   end

   // ------------------------------------------------------------- scoreboard
   always @(negedge clk_in) begin
      if (chk_on) begin
         check("trigger",    64'(tx_trigger_out), 64'(m_trig));
         check("tx_data",    64'(tx_data_out),    64'(m_out_word));
         check("tx_sel",     64'(tx_sel_out),     64'(m_mode));
         check("drop_count", 64'(drop_count_out), 64'(m_drop));
         check("timeout",    64'(timeout_out),    64'(m_to));
         if (tx_trigger_out) begin
            check("exp_q_depth_at_trigger", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) check("sent_word", 64'(tx_data_out), 64'(exp_q.pop_front()));
         end
      end
   end

   // Trigger and timeout log used by the directed scenarios.
   logic [31:0] trig_data_q[$];
   int          trig_cyc_q[$];
   bit          trig_sel_q[$];
   int          to_rise_cyc = -1;
   bit          to_prev     = 1'b0;

   always @(negedge clk_in) begin
      if (tx_trigger_out) begin
         trig_data_q.push_back(tx_data_out);
         trig_cyc_q.push_back(cyc);
         trig_sel_q.push_back(tx_sel_out);
      end
      if (timeout_out && !to_prev) to_rise_cyc = cyc;
      to_prev = timeout_out;
   end

   // --------------------------------------------------------------- driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick(2);
      rst_in = 1'b0;
   endtask

   task automatic clear_logs();
      trig_data_q.delete();
      trig_cyc_q.delete();
      trig_sel_q.delete();
      to_rise_cyc = -1;
   endtask

   task automatic pulse_single(input logic [15:0] d);
      single_data_in  = d;
      single_valid_in = 1'b1;
      tick(1);
      single_valid_in = 1'b0;
   endtask

   task automatic pulse_dual(input logic [31:0] d);
      dual_data_in  = d;
      dual_valid_in = 1'b1;
      tick(1);
      dual_valid_in = 1'b0;
   endtask

   task automatic tx_cfg(input int dly, input int len, input bit never);
      tx_delay = dly;
      tx_len   = len;
      tx_never = never;
   endtask

   // ------------------------------------------------------------------ stimulus
   int s_cyc;

   initial begin
      tick(1);
      do_reset();
      chk_on = 1'b1;
      check("reset_trigger", 64'(tx_trigger_out), 64'd0);
      check("reset_data",    64'(tx_data_out),    64'd0);
      check("reset_state",   64'(fsm_state_out),  64'd0);

      // Single-mode latency.
      tx_cfg(1, 200, 1'b0);
      clear_logs();
      enable_in = 1'b1;
      mode_in   = 1'b0;
      tick(2);
      s_cyc = cyc;
      pulse_single(16'hBEEF);
      tick(220);
      check("s1_trig_count", 64'(trig_data_q.size()), 64'd1);
      if (trig_data_q.size() > 0) begin
         check("s1_latency", 64'(trig_cyc_q[0] - s_cyc), 64'd2);
         check("s1_data",    64'(trig_data_q[0]),       64'h0000BEEF);
         check("s1_sel",     64'(trig_sel_q[0]),        64'd0);
      end

      // Overwrite while busy.
      do_reset();
      clear_logs();
      tx_cfg(1, 100, 1'b0);
      tick(2);
      pulse_single(16'h0001);
      tick(9);
      pulse_single(16'h0002);
      tick(9);
      pulse_single(16'h0003);
      tick(230);
      check("s2_trig_count", 64'(trig_data_q.size()), 64'd2);
      if (trig_data_q.size() == 2) begin
         check("s2_first",  64'(trig_data_q[0]), 64'h1);
         check("s2_second", 64'(trig_data_q[1]), 64'h3);
      end
      check("s2_drop", 64'(drop_count_out), 64'd1);

      // Dual decimation, with single strobes ignored.
      do_reset();
      clear_logs();
      tx_cfg(1, 3, 1'b0);
      mode_in = 1'b1;
      tick(2);
      for (int i = 1; i <= 4; i++) begin
         pulse_dual(32'(i));
         tick(3);
         pulse_single(16'h5A50 + 16'(i));
         tick(4);
      end
      tick(10);
      check("s3_trig_count", 64'(trig_data_q.size()), 64'd2);
      if (trig_data_q.size() == 2) begin
         check("s3_first",  64'(trig_data_q[0]), 64'd2);
         check("s3_second", 64'(trig_data_q[1]), 64'd4);
         check("s3_sel",    64'(trig_sel_q[1]),  64'd1);
      end

      // Mode switch while the transmitter is busy.
      mode_in = 1'b0;
      do_reset();
      clear_logs();
      tx_cfg(1, 40, 1'b0);
      tick(2);
      pulse_single(16'h1111);
      tick(10);
      pulse_single(16'h2222);
      tick(3);
      mode_in = 1'b1;
      tick(5);
      check("s4_sel_while_busy", 64'(tx_sel_out), 64'd0);
      tick(35);
      check("s4_sel_after", 64'(tx_sel_out), 64'd1);
      pulse_dual(32'hAAAA0001);
      tick(6);
      pulse_dual(32'hAAAA0002);
      tick(10);
      check("s4_trig_count", 64'(trig_data_q.size()), 64'd2);
      if (trig_data_q.size() == 2) begin
         check("s4_first",  64'(trig_data_q[0]), 64'h00001111);
         check("s4_second", 64'(trig_data_q[1]), 64'hAAAA0002);
      end
      check("s4_drop", 64'(drop_count_out), 64'd0);
      tick(50);

      // Busy timeout.
      mode_in = 1'b0;
      do_reset();
      clear_logs();
      tx_cfg(1, 4, 1'b1);
      tick(2);
      pulse_single(16'hC001);
      tick(3);
      pulse_single(16'hC002);
      tick(20);
      check("s5_trig_count", 64'(trig_data_q.size()), 64'd2);
      check("s5_timeout",    64'(timeout_out),        64'd1);
      if (trig_data_q.size() == 2) begin
         check("s5_timeout_delay", 64'(to_rise_cyc - trig_cyc_q[0]),   64'd8);
         check("s5_retrigger",     64'(trig_cyc_q[1] - to_rise_cyc),   64'd1);
         check("s5_second",        64'(trig_data_q[1]),                64'h0000C002);
      end

      // Reset during WAIT_BUSY, then enable low.
      clear_logs();
      pulse_single(16'h7777);
      tick(2);
      rst_in = 1'b1;
      tick(1);
      rst_in = 1'b0;
      check("s6_rst_trigger", 64'(tx_trigger_out), 64'd0);
      check("s6_rst_data",    64'(tx_data_out),    64'd0);
      check("s6_rst_sel",     64'(tx_sel_out),     64'd0);
      check("s6_rst_drop",    64'(drop_count_out), 64'd0);
      check("s6_rst_timeout", 64'(timeout_out),    64'd0);
      check("s6_rst_state",   64'(fsm_state_out),  64'd0);
      tx_cfg(1, 5, 1'b0);
      clear_logs();
      enable_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse_single(16'h0100 + 16'(i));
         tick(1);
      end
      tick(10);
      enable_in = 1'b1;
      tick(5);
      check("s6_en_trig_count", 64'(trig_data_q.size()), 64'd0);
      check("s6_en_drop",       64'(drop_count_out),     64'd0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_in = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 199) == 0) mode_in = ~mode_in;
         if ($urandom_range(0, 149) == 0) enable_in = ~enable_in;
         if ($urandom_range(0, 49) == 0)
            tx_cfg(int'($urandom_range(1, 2)), int'($urandom_range(1, 30)), ($urandom_range(0, 7) == 0));
         single_valid_in = ($urandom_range(0, 5) == 0);
         single_data_in  = 16'($urandom);
         dual_valid_in   = ($urandom_range(0, 3) == 0);
         dual_data_in    = $urandom;
         tick(1);
      end
      rst_in          = 1'b0;
      single_valid_in = 1'b0;
      dual_valid_in   = 1'b0;
      tx_cfg(1, 3, 1'b0);
      tick(100);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
